// File: rtl/hd44780_update_scheduler.sv
// hd44780_update_scheduler
//
// Turns one-cycle event pulses from N_SRC sources into display-refresh
// requests for an HD44780 write sequencer. Each source is filtered by the
// enable mask of the current mode. Surviving events are merged into one
// pending set. A single request is raised and held until the driver accepts
// it. After acceptance, an optional hold-off interval must pass before the
// next request can be raised.
//
// Ports:
//   i_clk          system clock (all state on rising edge)
//   i_rst          synchronous active-high reset
//   i_src_pulse    [N_SRC] one-cycle event pulses, bit n = source n
//   i_mask_run     [N_SRC] source enables while i_wr = 0
//   i_mask_edit    [N_SRC] source enables while i_wr = 1
//   i_wr           mode select: 0 = run, 1 = edit
//   i_ena          driver accept strobe, only meaningful while a request is up
//   o_update_pulse request level, held until accepted
//   o_reason       [N_SRC] pending set captured when the request was issued
//   o_mode_chg     request was (also) caused by a change of i_wr
//   o_coalesce_cnt [8] saturating count of edges where an event hit a
//                  source that was already pending

module hd44780_update_scheduler #(
    parameter int N_SRC     = 4,
    parameter int HOLDOFF   = 16,
    parameter int HOLDOFF_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [N_SRC-1:0] i_src_pulse,
    input  logic [N_SRC-1:0] i_mask_run,
    input  logic [N_SRC-1:0] i_mask_edit,
    input  logic             i_wr,
    input  logic             i_ena,
    output logic             o_update_pulse,
    output logic [N_SRC-1:0] o_reason,
    output logic             o_mode_chg,
    output logic [7:0]       o_coalesce_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t               state_reg, state_next;
    logic [HOLDOFF_W-1:0] counter_reg, counter_next;
    logic [N_SRC-1:0]     pending_reg, pending_next;
    logic                 mode_chg_pend_reg, mode_chg_pend_next;
    logic                 wr_reg;
    logic [N_SRC-1:0]     reason_reg;
    logic                 mode_chg_reg;
    logic [7:0]           coal_cnt_reg;

    logic [N_SRC-1:0]     mask_eff;
    logic [N_SRC-1:0]     acc;
    logic [N_SRC-1:0]     issued;
    logic                 mode_changed;
    logic                 issue;
    logic                 coalesce_hit;

    // ------------------------------------------------------------------
    // Event filtering and pending-set bookkeeping
    // ------------------------------------------------------------------
    assign mask_eff     = i_wr ? i_mask_edit : i_mask_run;
    assign acc          = i_src_pulse & mask_eff;
    assign mode_changed = i_wr ^ wr_reg;
    assign issue        = (state_reg == S_IDLE) && (state_next == S_REQ);
    // Bits handed to the request on this edge leave the pending set; a fresh
    // event on the same bit re-arms it, so nothing is lost.
    assign issued       = issue ? pending_reg : '0;
    assign coalesce_hit = |(acc & pending_reg & ~issued);

    // On a mode change, stale pending bits that the new mode does not
    // enable are dropped rather than producing a spurious refresh later.
    generate
        for (genvar gi = 0; gi < N_SRC; gi++) begin : g_pending
            assign pending_next[gi] = (pending_reg[gi] & ~issued[gi]
                                       & (~mode_changed | mask_eff[gi]))
                                      | acc[gi];
        end
    endgenerate

    // A change arriving on the issuing edge belongs to the next request.
    assign mode_chg_pend_next = mode_changed | (mode_chg_pend_reg & ~issue);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg   <= S_IDLE;
            counter_reg <= '0;
        end else begin
            state_reg   <= state_next;
            counter_reg <= counter_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        counter_next = counter_reg;
        case (state_reg)
            S_IDLE: begin
                if ((pending_reg != '0) || mode_chg_pend_reg) begin
                    state_next = S_REQ;
                end
            end
            S_REQ: begin
                if (i_ena) begin
                    if (HOLDOFF == 0) begin
                        state_next = S_IDLE;
                    end else begin
                        state_next   = S_HOLD;
                        counter_next = HOLDOFF_W'(HOLDOFF);
                    end
                end
            end
            S_HOLD: begin
                // Counter runs down to zero, then one more edge to leave,
                // giving a low gap of HOLDOFF+2 cycles between requests.
                if (counter_reg == '0) begin
                    state_next = S_IDLE;
                end else begin
                    counter_next = counter_reg - HOLDOFF_W'(1);
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        o_update_pulse = (state_reg == S_REQ);
        o_reason       = reason_reg;
        o_mode_chg     = mode_chg_reg;
        o_coalesce_cnt = coal_cnt_reg;
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pending_reg       <= '0;
            mode_chg_pend_reg <= 1'b0;
            wr_reg            <= i_wr;
            reason_reg        <= '0;
            mode_chg_reg      <= 1'b0;
            coal_cnt_reg      <= '0;
        end else begin
            pending_reg       <= pending_next;
            mode_chg_pend_reg <= mode_chg_pend_next;
            wr_reg            <= i_wr;
            if (issue) begin
                reason_reg   <= pending_reg;
                mode_chg_reg <= mode_chg_pend_reg;
            end
            if (coalesce_hit && (coal_cnt_reg != 8'hFF)) begin
                coal_cnt_reg <= coal_cnt_reg + 8'd1;
            end
        end
    end

endmodule
